// File: rtl/ball_motion_pkg.sv
// Shared constants for the ball motion controller: stop codes, state encoding, code ranges.
// Also holds the move-code helper used for both axes.
package ball_motion_pkg;

    localparam int H_STOP_DEF = 11;
    localparam int V_STOP_DEF = 10;

    localparam int H_CODE_MIN = 8;
    localparam int H_CODE_MAX = 14;
    localparam int V_CODE_MIN = 7;
    localparam int V_CODE_MAX = 13;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_SERVE_WAIT = 2'd1,
        ST_MOVING     = 2'd2,
        ST_PAUSED     = 2'd3
    } state_t;

    // dir=0 moves positive (stop+speed), dir=1 moves negative (stop-speed)
    function automatic logic [3:0] move_code(input logic [3:0] stop, input logic dir,
                                             input logic [1:0] spd);
        return dir ? (stop - {2'b00, spd}) : (stop + {2'b00, spd});
    endfunction

endpackage

// File: rtl/collide_edge_detect.sv
// Two-flop synchronizer for a raw collide level plus a rising-edge pulse.
// The pulse appears 2 cycles after the raw rise; a held level yields one pulse.
module collide_edge_detect (
    input  logic clk,
    input  logic ball_reset,
    input  logic collide,
    output logic rise
);
    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    always_ff @(posedge clk or posedge ball_reset) begin
        if (ball_reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= collide;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign rise = sync2_q & ~prev_q;

endmodule

// File: rtl/ball_motion_ctrl.sv
// Sequences ball move codes (serve/pause/miss), turns wall hits into reversals, ramps speed.
// Codes change only on frame_tick (outputs registered, +1 cycle); miss stops the ball next cycle.
module ball_motion_ctrl
    import ball_motion_pkg::*;
#(
    parameter int H_STOP              = H_STOP_DEF,
    parameter int V_STOP              = V_STOP_DEF,
    parameter int MAX_SPEED           = 3,
    parameter int BOUNCES_PER_SPEEDUP = 4
) (
    input  logic       clk,
    input  logic       ball_reset,
    input  logic       frame_tick,
    input  logic       hcollide,
    input  logic       vcollide,
    input  logic       serve,
    input  logic [1:0] serve_dir,
    input  logic       pause,
    input  logic       miss,
    output logic [3:0] hmove,
    output logic [3:0] vmove,
    output logic [1:0] state,
    output logic [1:0] speed,
    output logic [7:0] bounce_count
);
    localparam logic [3:0] H_STOP4 = H_STOP[3:0];
    localparam logic [3:0] V_STOP4 = V_STOP[3:0];
    localparam logic [1:0] MAX_SPD = MAX_SPEED[1:0];

    state_t     state_q;
    logic       hdir, vdir, hpend, vpend;
    logic       hedge, vedge;
    logic [1:0] n_bounce;
    logic [8:0] bc_sum;
    logic [7:0] app_bc;
    logic [1:0] app_speed;
    logic       app_hdir, app_vdir, crossed;

    collide_edge_detect u_hedge (.clk(clk), .ball_reset(ball_reset), .collide(hcollide), .rise(hedge));
    collide_edge_detect u_vedge (.clk(clk), .ball_reset(ball_reset), .collide(vcollide), .rise(vedge));

    // Result of applying the pending bounces at this frame boundary
    always_comb begin
        n_bounce  = {1'b0, hpend} + {1'b0, vpend};
        bc_sum    = {1'b0, bounce_count} + {7'b0, n_bounce};
        app_bc    = bc_sum[8] ? 8'hFF : bc_sum[7:0];
        crossed   = (int'(app_bc) / BOUNCES_PER_SPEEDUP) != (int'(bounce_count) / BOUNCES_PER_SPEEDUP);
        app_speed = (crossed && (speed < MAX_SPD)) ? speed + 2'd1 : speed;
        app_hdir  = hdir ^ hpend;
        app_vdir  = vdir ^ vpend;
    end

    always_ff @(posedge clk or posedge ball_reset) begin
        if (ball_reset) begin
            state_q      <= ST_IDLE;
            hmove        <= H_STOP4;
            vmove        <= V_STOP4;
            speed        <= 2'd1;
            bounce_count <= 8'd0;
            hdir         <= 1'b0;
            vdir         <= 1'b0;
            hpend        <= 1'b0;
            vpend        <= 1'b0;
        end else if (miss) begin
            state_q <= ST_IDLE;
            hmove   <= H_STOP4;
            vmove   <= V_STOP4;
            hpend   <= 1'b0;
            vpend   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (serve) begin
                        state_q      <= ST_SERVE_WAIT;
                        hdir         <= serve_dir[1];
                        vdir         <= serve_dir[0];
                        speed        <= 2'd1;
                        bounce_count <= 8'd0;
                        hpend        <= 1'b0;
                        vpend        <= 1'b0;
                    end
                end
                ST_SERVE_WAIT: begin
                    if (frame_tick) begin
                        state_q <= ST_MOVING;
                        hmove   <= move_code(H_STOP4, hdir, speed);
                        vmove   <= move_code(V_STOP4, vdir, speed);
                    end
                end
                ST_MOVING: begin
                    if (frame_tick) begin
                        hdir         <= app_hdir;
                        vdir         <= app_vdir;
                        bounce_count <= app_bc;
                        speed        <= app_speed;
                        // an edge landing on the boundary belongs to the next frame
                        hpend        <= hedge;
                        vpend        <= vedge;
                        if (pause) begin
                            state_q <= ST_PAUSED;
                            hmove   <= H_STOP4;
                            vmove   <= V_STOP4;
                        end else begin
                            hmove <= move_code(H_STOP4, app_hdir, app_speed);
                            vmove <= move_code(V_STOP4, app_vdir, app_speed);
                        end
                    end else begin
                        if (hedge) hpend <= 1'b1;
                        if (vedge) vpend <= 1'b1;
                    end
                end
                ST_PAUSED: begin
                    if (frame_tick && !pause) begin
                        state_q <= ST_MOVING;
                        hmove   <= move_code(H_STOP4, hdir, speed);
                        vmove   <= move_code(V_STOP4, vdir, speed);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// Scoreboard bench for ball_motion_ctrl: a behavioural model pushes expected outputs per event.
module tb_ball_motion_ctrl;
    logic       clk = 1'b0;
    logic       ball_reset = 1'b1;
    logic       frame_tick = 1'b0;
    logic       hcollide = 1'b0;
    logic       vcollide = 1'b0;
    logic       serve = 1'b0;
    logic [1:0] serve_dir = 2'b00;
    logic       pause = 1'b0;
    logic       miss = 1'b0;
    logic [3:0] hmove, vmove;
    logic [1:0] state, speed;
    logic [7:0] bounce_count;

    always #5 clk = ~clk;

    ball_motion_ctrl dut (
        .clk(clk), .ball_reset(ball_reset), .frame_tick(frame_tick),
        .hcollide(hcollide), .vcollide(vcollide), .serve(serve),
        .serve_dir(serve_dir), .pause(pause), .miss(miss),
        .hmove(hmove), .vmove(vmove), .state(state), .speed(speed),
        .bounce_count(bounce_count)
    );

    typedef struct {
        int st;
        int hm;
        int vm;
        int sp;
        int bc;
    } exp_t;

    exp_t sb[$];

    int m_state, m_hdir, m_vdir, m_speed, m_bc, m_hpend, m_vpend;
    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t snap();
        exp_t e;
        e.st = m_state;
        e.sp = m_speed;
        e.bc = m_bc;
        if (m_state == 2) begin
            e.hm = (m_hdir != 0) ? 11 - m_speed : 11 + m_speed;
            e.vm = (m_vdir != 0) ? 10 - m_speed : 10 + m_speed;
        end else begin
            e.hm = 11;
            e.vm = 10;
        end
        return e;
    endfunction

    task automatic model_reset();
        m_state = 0; m_hdir = 0; m_vdir = 0; m_speed = 1;
        m_bc = 0; m_hpend = 0; m_vpend = 0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 1, 0);
        end else begin
            e = sb.pop_front();
            chk({tag, "_state"}, state, e.st);
            chk({tag, "_hmove"}, hmove, e.hm);
            chk({tag, "_vmove"}, vmove, e.vm);
            chk({tag, "_speed"}, speed, e.sp);
            chk({tag, "_bcount"}, bounce_count, e.bc);
        end
    endtask

    task automatic do_frame(input string tag);
        int nb, nbc;
        if (m_state == 1) begin
            m_state = 2;
        end else if (m_state == 2) begin
            nb  = m_hpend + m_vpend;
            nbc = (m_bc + nb > 255) ? 255 : m_bc + nb;
            if ((nbc / 4) != (m_bc / 4) && m_speed < 3) m_speed++;
            m_bc = nbc;
            if (m_hpend != 0) m_hdir = 1 - m_hdir;
            if (m_vpend != 0) m_vdir = 1 - m_vdir;
            m_hpend = 0; m_vpend = 0;
            if (pause) m_state = 3;
        end else if (m_state == 3 && !pause) begin
            m_state = 2;
        end
        frame_tick = 1'b1;
        sb.push_back(snap());
        cyc();
        frame_tick = 1'b0;
        check_out(tag);
    endtask

    // raw collide pulse, then enough idle cycles for it to land in the pending flags
    task automatic collide(input bit h, input bit v);
        if (m_state == 2) begin
            if (h) m_hpend = 1;
            if (v) m_vpend = 1;
        end
        hcollide = h; vcollide = v;
        cyc();
        hcollide = 1'b0; vcollide = 1'b0;
        repeat (5) cyc();
    endtask

    task automatic do_serve(input logic [1:0] dir);
        if (m_state == 0) begin
            m_state = 1; m_hdir = dir[1]; m_vdir = dir[0];
            m_speed = 1; m_bc = 0; m_hpend = 0; m_vpend = 0;
        end
        serve = 1'b1; serve_dir = dir;
        sb.push_back(snap());
        cyc();
        serve = 1'b0;
        check_out("serve");
    endtask

    task automatic do_miss();
        m_state = 0; m_hpend = 0; m_vpend = 0;
        miss = 1'b1;
        sb.push_back(snap());
        cyc();
        miss = 1'b0;
        check_out("miss");
    endtask

    initial begin
        model_reset();
        repeat (3) cyc();
        sb.push_back(snap());
        check_out("reset");
        ball_reset = 1'b0;
        repeat (2) cyc();

        do_serve(2'b01);
        do_frame("serve_go");

        collide(1'b0, 1'b1);
        do_frame("vbounce");

        collide(1'b1, 1'b1);
        collide(1'b1, 1'b0);
        do_frame("dual_bounce");

        for (int i = 0; i < 9; i++) begin
            collide(1'b1, 1'b0);
            do_frame("ramp");
        end

        // level held high across frames is a single bounce
        hcollide = 1'b1;
        repeat (5) cyc();
        m_hpend = 1;
        do_frame("held_1");
        do_frame("held_2");
        hcollide = 1'b0;
        repeat (4) cyc();

        pause = 1'b1;
        do_frame("pause_enter");
        collide(1'b1, 1'b1);
        do_frame("pause_hold");
        pause = 1'b0;
        do_frame("pause_exit");
        do_frame("after_pause");

        do_serve(2'b10);
        collide(1'b0, 1'b1);
        do_miss();
        collide(1'b1, 1'b1);
        do_frame("idle_frame");

        do_serve(2'b10);
        do_frame("serve2_go");
        collide(1'b1, 1'b0);
        ball_reset = 1'b1;
        #1;
        model_reset();
        sb.push_back(snap());
        check_out("async_reset");
        cyc();
        ball_reset = 1'b0;
        repeat (2) cyc();
        do_frame("post_reset_frame");

        chk("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
